clk_div_monitor: RTL and testbench

//   Receive-side checker for divided clocks produced by the clk_div family.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_sync.sv | 29 ++
 rtl/clk_div_monitor.sv | 132 +++++++++++++
 tb/tb_clk_div_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div family of monitors.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } mon_state_t;

    localparam int STUCK_MULT = 4;

    // Bits needed to count up to the stuck threshold for a given divide ratio.
    function automatic int cnt_width(input int div);
        return $clog2(STUCK_MULT * div + 1);
    endfunction

endpackage

// File: rtl/clk_div_sync.sv
// Two-flop synchroniser for a slow clock-like input, plus a third flop for rise detect.
module clk_div_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures period/high time, tracks lock, flags mismatch and stall.
// Optional duty-cycle check when DUTY_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first rise; partial period discarded
// ARM   | first full period in progress
// TRACK | every rise closes a checked period
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int DIV        = 3,
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             period_err,
    output logic             stuck
);

    localparam int ST_W = cnt_width(DIV);
    localparam int GD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [ST_W-1:0] STUCK_LOAD = ST_W'(STUCK_MULT * DIV - 1);

    mon_state_t state, state_nxt;

    logic             s_level;
    logic             rise;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [ST_W-1:0]  stuck_tmr;
    logic [GD_W-1:0]  good_cnt;
    logic             check;
    logic             stuck_hit;
    logic             duty_ok;
    logic             good_period;

    clk_div_sync u_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (div_clk),
        .level (s_level),
        .rise  (rise)
    );

    // Stall timer is separate from run_cnt so it still fires when run_cnt saturates.
    assign check     = rise && (state != IDLE);
    assign stuck_hit = !rise && (state != IDLE) && (stuck_tmr == ST_W'(1));

`ifdef DUTY_CHECK_EN
    logic [CNT_W+2:0] duty_off;
    // 2*hi - period + 1, taken modulo; in-tolerance values land on 0..2.
    assign duty_off = {2'b00, hi_cnt, 1'b0} - {3'b000, run_cnt} + (CNT_W+3)'(1);
    assign duty_ok  = (duty_off <= (CNT_W+3)'(2));
`else
    assign duty_ok  = 1'b1;
`endif

    assign good_period = (run_cnt == CNT_W'(DIV)) && duty_ok;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = ARM;
            ARM:     if (rise) state_nxt = TRACK;
                     else if (stuck_hit) state_nxt = IDLE;
            TRACK:   if (stuck_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt    <= '0;
            hi_cnt     <= '0;
            stuck_tmr  <= '0;
            good_cnt   <= '0;
            period     <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            period_err <= 1'b0;
            locked     <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            meas_valid <= check;
            period_err <= check && !good_period;

            if (rise) begin
                run_cnt   <= CNT_W'(1);
                hi_cnt    <= CNT_W'(s_level);
                stuck_tmr <= STUCK_LOAD;
                stuck     <= 1'b0;
            end else begin
                if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
                if (s_level && (hi_cnt != '1)) hi_cnt <= hi_cnt + CNT_W'(1);
                if (stuck_tmr != '0) stuck_tmr <= stuck_tmr - ST_W'(1);
            end

            if (check) begin
                period   <= run_cnt;
                high_cnt <= hi_cnt;
                if (good_period) begin
                    if (good_cnt != GD_W'(LOCK_COUNT)) good_cnt <= good_cnt + GD_W'(1);
                    if (good_cnt >= GD_W'(LOCK_COUNT - 1)) locked <= 1'b1;
                end else begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            end

            if (stuck_hit) begin
                stuck    <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: DIV=3 main instance, DIV=4 duty instance, DIV=2/CNT_W=3 edge instance.
module tb_clk_div_monitor;

    logic clock_in = 1'b0;
    logic reset_n  = 1'b0;
    logic div3 = 1'b0;
    logic div4 = 1'b0;
    logic div2 = 1'b0;

    logic [7:0] period3, high3;
    logic       mv3_o, lk3, pe3, st3;
    logic [7:0] period4, high4;
    logic       mv4_o, lk4, pe4, st4;
    logic [2:0] period2, high2;
    logic       mv2_o, lk2, pe2, st2;

    int checks = 0;
    int errors = 0;

    int mv3 = 0, err3 = 0, mv4 = 0, err4 = 0, mv2 = 0, err2 = 0;
    int lp3 = 0, lh3 = 0, lp4 = 0, lh4 = 0, lp2 = 0;

    clk_div_monitor #(.DIV(3), .CNT_W(8), .LOCK_COUNT(4)) dut3 (
        .clock_in(clock_in), .reset_n(reset_n), .div_clk(div3),
        .period(period3), .high_cnt(high3), .meas_valid(mv3_o),
        .locked(lk3), .period_err(pe3), .stuck(st3)
    );

    clk_div_monitor #(.DIV(4), .CNT_W(8), .LOCK_COUNT(4)) dut4 (
        .clock_in(clock_in), .reset_n(reset_n), .div_clk(div4),
        .period(period4), .high_cnt(high4), .meas_valid(mv4_o),
        .locked(lk4), .period_err(pe4), .stuck(st4)
    );

    clk_div_monitor #(.DIV(2), .CNT_W(3), .LOCK_COUNT(4)) dut2 (
        .clock_in(clock_in), .reset_n(reset_n), .div_clk(div2),
        .period(period2), .high_cnt(high2), .meas_valid(mv2_o),
        .locked(lk2), .period_err(pe2), .stuck(st2)
    );

    always #5 clock_in = ~clock_in;

    // Pulse outputs are accumulated here so directed steps can check them as counts.
    always @(posedge clock_in) begin
        #2;
        if (mv3_o) begin mv3++; lp3 = int'(period3); lh3 = int'(high3); end
        if (pe3) err3++;
        if (mv4_o) begin mv4++; lp4 = int'(period4); lh4 = int'(high4); end
        if (pe4) err4++;
        if (mv2_o) begin mv2++; lp2 = int'(period2); end
        if (pe2) err2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_div(input int sel, input logic v);
        case (sel)
            3:       div3 = v;
            4:       div4 = v;
            default: div2 = v;
        endcase
    endtask

    task automatic drive(input int sel, input int hi, input int lo);
        for (int i = 0; i < hi + lo; i++) begin
            @(negedge clock_in);
            set_div(sel, i < hi);
        end
    endtask

    task automatic hold(input int sel, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock_in);
            set_div(sel, v);
        end
    endtask

    initial begin
        #1000;
        chk("rst_period",     period3,  0);
        chk("rst_high",       high3,    0);
        chk("rst_meas_valid", mv3_o,    0);
        chk("rst_locked",     lk3,      0);
        chk("rst_period_err", pe3,      0);
        chk("rst_stuck",      st3,      0);
        reset_n = 1'b1;

        // Acquisition at DIV=3 with a 2/1 divider
        drive(3, 2, 1); drive(3, 2, 1);
        chk("acq_no_mv_first_rise", mv3, 0);
        drive(3, 2, 1);
        chk("acq_first_mv",     mv3, 1);
        chk("acq_first_period", lp3, 3);
        chk("acq_first_high",   lh3, 2);
        drive(3, 2, 1); drive(3, 2, 1);
        chk("acq_locked_3_good", lk3, 0);
        drive(3, 2, 1);
        chk("acq_locked_4_good", lk3, 1);
        chk("acq_mv_count",      mv3, 4);
        chk("acq_no_err",        err3, 0);

        // One stretched period of 4
        drive(3, 3, 1); drive(3, 2, 1);
        chk("stretch_still_locked", lk3, 1);
        chk("stretch_no_err_yet",   err3, 0);
        drive(3, 2, 1);
        chk("stretch_mv",     mv3, 7);
        chk("stretch_period", lp3, 4);
        chk("stretch_high",   lh3, 3);
        chk("stretch_err",    err3, 1);
        chk("stretch_unlock", lk3, 0);
        drive(3, 2, 1); drive(3, 2, 1); drive(3, 2, 1);
        chk("relock_3_good", lk3, 0);
        drive(3, 2, 1);
        chk("relock_4_good", lk3, 1);
        chk("relock_mv",     mv3, 11);

        // Stall: div_clk held low
        hold(3, 1'b0, 11);
        chk("stall_11_stuck",  st3, 0);
        chk("stall_11_locked", lk3, 1);
        hold(3, 1'b0, 1);
        chk("stall_12_stuck",  st3, 1);
        chk("stall_12_locked", lk3, 0);
        chk("stall_mv",        mv3, 12);
        drive(3, 2, 1);
        chk("stall_rise_pending", st3, 1);
        drive(3, 2, 1);
        chk("stall_cleared",   st3, 0);
        chk("stall_idle_no_mv", mv3, 12);
        drive(3, 2, 1); drive(3, 2, 1); drive(3, 2, 1);
        chk("stall_relock_early", lk3, 0);
        drive(3, 2, 1);
        chk("stall_relock",     lk3, 1);
        chk("stall_relock_mv",  mv3, 16);
        chk("stall_err_total",  err3, 1);

        // Reset pulse while locked
        reset_n = 1'b0;
        #1;
        chk("mid_rst_locked", lk3, 0);
        chk("mid_rst_period", period3, 0);
        chk("mid_rst_high",   high3, 0);
        chk("mid_rst_mv",     mv3_o, 0);
        chk("mid_rst_stuck",  st3, 0);
        @(negedge clock_in);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) drive(3, 2, 1);
        chk("reacq_early", lk3, 0);
        drive(3, 2, 1);
        chk("reacq_locked", lk3, 1);
        chk("reacq_mv",     mv3, 20);

        // DIV=4, 3/1 then 2/2
        for (int k = 0; k < 6; k++) drive(4, 3, 1);
        chk("d4_31_mv",     mv4, 5);
        chk("d4_31_period", lp4, 4);
        chk("d4_31_high",   lh4, 3);
`ifdef DUTY_CHECK_EN
        chk("d4_31_err",    err4, 5);
        chk("d4_31_locked", lk4, 0);
`else
        chk("d4_31_err",    err4, 0);
        chk("d4_31_locked", lk4, 1);
`endif
        for (int k = 0; k < 6; k++) drive(4, 2, 2);
        chk("d4_22_mv",     mv4, 11);
        chk("d4_22_high",   lh4, 2);
        chk("d4_22_locked", lk4, 1);
`ifdef DUTY_CHECK_EN
        chk("d4_22_err",    err4, 6);
`else
        chk("d4_22_err",    err4, 0);
`endif

        // DIV=2, CNT_W=3: held high after one period of 2
        drive(2, 1, 1);
        hold(2, 1'b1, 10);
        chk("d2_period",    lp2, 2);
        chk("d2_mv",        mv2, 1);
        chk("d2_sat_7",     dut2.run_cnt, 7);
        chk("d2_stuck_7",   st2, 0);
        hold(2, 1'b1, 1);
        chk("d2_stuck_8",   st2, 1);
        hold(2, 1'b1, 20);
        chk("d2_no_wrap",   dut2.run_cnt, 7);
        chk("d2_stuck_hold", st2, 1);
        chk("d2_no_err",    err2, 0);
        hold(2, 1'b0, 2);
        drive(2, 1, 1); drive(2, 1, 1);
        chk("d2_stuck_clear", st2, 0);
        chk("d2_idle_no_mv",  mv2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
